rhd_frame_packetizer: RTL and testbench
=======================================

# rhd_frame_packetizer

Packs the RHD acquisition engine's per-channel 16-bit samples into magic-number-framed, batched AXI4-Stream packets for the S2MM DMA path. Sits directly downstream of the RHD SPI/acquisition core and upstream of the clock-crossing FIFO into `clk_dma`. Batch size comes from the RHD AXI-Lite packet-length register (offset 0x8); enable comes from the RHD control register (offset 0x0, bit 0).

## Interface
- `NUM_CH`, 32: channels per frame; must be even, 2..64.
- `MAGIC`, 64'hC691199927021942: frame header constant.
- `rhd_aclk`  in  1  sole clock; all logic rises on it.
- `rhd_aresetn`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  acquisition run; level-sensitive.
- `batch_size`  in  8  frames per packet; 0 treated as 1; latched at packet start.
- `s_data`  in  16  channel sample.
- `s_first`  in  1  marks channel 0 of a frame; qualified by `s_valid`.
- `s_valid`  in  1  sample valid.
- `s_ready`  out  1  sample accepted when `s_valid && s_ready`.
- `m_tdata`  out  32  stream word.
- `m_tvalid`  out  1  stream valid.
- `m_tlast`  out  1  last word of packet.
- `m_tready`  in  1  downstream ready.
- `busy`  out  1  high whenever state is not IDLE.
- `sync_err`  out  1  sticky; `s_first` placement mismatch.

## Operation
- Frame = 3 + NUM_CH/2 words: W0 `MAGIC[31:0]`, W1 `MAGIC[63:32]`, W2 timestamp, W3.. channel pairs `{ch(2k+1), ch(2k)}` (even channel in [15:0]).
- Timestamp: 32-bit frame counter, 0 for first frame after start, +1 per frame, wraps 0xFFFFFFFF -> 0.
- States: IDLE, HDR0, HDR1, TSTAMP, DATA.
- IDLE -> HDR0 when `enable`=1; latch `batch_size` (0 -> 1); clear frame index, timestamp, `sync_err`.
- HDR0 -> HDR1 -> TSTAMP -> DATA, each advance on output word loaded into output register.
- DATA: channel counter 0..NUM_CH-1. Even channel stored in holding reg; odd channel forms a word with holding reg and loads output register.
- After word with channel NUM_CH-1: frame done. `m_tlast`=1 on that word if frame index = latched batch-1 OR `enable`=0 at that accept cycle. If tlast: enable=1 -> HDR0 (new packet, re-latch batch, timestamp continues); enable=0 -> IDLE. Else frame index+1, -> HDR0.
- `enable` falling mid-frame: frame completes; packet closes with tlast at that frame's end. Never truncate a frame.
- `sync_err` set if accepted sample has `s_first`=1 with channel counter ≠ 0, or `s_first`=0 with counter = 0. Data packing unaffected (no resync).
- `s_ready` = (state==DATA) && (counter even || !m_tvalid || m_tready). Outside DATA, `s_ready`=0.

## Timing
- Reset: state IDLE, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `s_ready`=0, `busy`=0, `sync_err`=0, counters 0.
- Single output register: loads when `!m_tvalid || m_tready`; holds tdata/tlast stable while `m_tvalid && !m_tready` (AXI-S rule). No combinational tready->tvalid path.
- `enable` rise -> `m_tvalid` for W0 two cycles later (cycle 1 IDLE->HDR0, cycle 2 W0 registered).
- With `m_tready` held 1: header words on consecutive cycles; data word valid 1 cycle after odd-channel accept; full throughput 1 sample/cycle.
- Backpressure: `s_ready` drops on odd channel while output stalled; even channel still accepted into holding reg.
- `rhd_aresetn` low mid-packet: immediate return to reset values; no tlast emitted.

## Test plan
- NUM_CH=32, batch_size=2, tready=1, feed 64 samples 0x0000..0x003F with `s_first` on 0 and 32 -> 38 words; W0=0x27021942, W1=0xC6911999, W2=0, W3=0x00010000; W21 timestamp=1; tlast only on word 37.
- batch_size=0, enable=1, three frames -> three packets of 19 words, tlast on each word 18; timestamps 0,1,2.
- Random `m_tready` (50%) during two frames -> identical word sequence to tready=1 run; tdata stable during every stall; no sample lost.
- Drop `enable` after channel 10 of frame 0, batch_size=4 -> frame 0 completes, tlast on word 18, `busy`=0 next cycle; restart gives timestamp 0.
- `s_first`=1 on channel 5 -> `sync_err`=1 and stays set; cleared on next IDLE->HDR0 start.
- Assert `rhd_aresetn`=0 while `m_tvalid && !m_tready` in DATA -> all outputs at reset values asynchronously; enable afterwards produces W0 cleanly.

Source files
------------

// File: rtl/rhd_frame_packetizer.sv
// Packs per-channel 16-bit RHD samples into MAGIC/timestamp-framed, batched
// AXI4-Stream packets behind a single output register.
module rhd_frame_packetizer #(
    parameter int unsigned NUM_CH = 32,
    parameter logic [63:0] MAGIC  = 64'hC691199927021942
) (
    input  logic        rhd_aclk,
    input  logic        rhd_aresetn,
    input  logic        enable,
    input  logic [7:0]  batch_size,
    input  logic [15:0] s_data,
    input  logic        s_first,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic        busy,
    output logic        sync_err
);

    localparam int unsigned CW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        TSTAMP,
        DATA
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [15:0]   hold_q, hold_d;
    logic [7:0]    frame_q, frame_d;
    logic [7:0]    batch_q, batch_d;
    logic [31:0]   ts_q, ts_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          sync_q, sync_d;

    logic out_load;
    logic accept;
    logic last_ch;
    logic pkt_end;
    logic [7:0] batch_eff;

    assign out_load  = !tvalid_q || m_tready;
    assign s_ready   = (state_q == DATA) && (!ch_q[0] || out_load);
    assign accept    = s_valid && s_ready;
    assign last_ch   = (ch_q == CW'(NUM_CH - 1));
    assign pkt_end   = (frame_q == (batch_q - 8'd1)) || !enable;
    assign batch_eff = (batch_size == 8'd0) ? 8'd1 : batch_size;

    // Next-state and output-register update
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        hold_d   = hold_q;
        frame_d  = frame_q;
        batch_d  = batch_q;
        ts_d     = ts_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        sync_d   = sync_q;

        if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = HDR0;
                    batch_d = batch_eff;
                    frame_d = 8'd0;
                    ts_d    = 32'd0;
                    sync_d  = 1'b0;
                    ch_d    = '0;
                end
            end
            HDR0: begin
                if (out_load) begin
                    tdata_d  = MAGIC[31:0];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                if (out_load) begin
                    tdata_d  = MAGIC[63:32];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    state_d  = TSTAMP;
                end
            end
            TSTAMP: begin
                if (out_load) begin
                    tdata_d  = ts_q;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    ch_d     = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    // Framing check only flags; packing continues regardless
                    if (s_first != (ch_q == '0)) begin
                        sync_d = 1'b1;
                    end
                    if (!ch_q[0]) begin
                        hold_d = s_data;
                        ch_d   = ch_q + CW'(1);
                    end else begin
                        tdata_d  = {s_data, hold_q};
                        tvalid_d = 1'b1;
                        tlast_d  = last_ch && pkt_end;
                        if (last_ch) begin
                            ch_d = '0;
                            ts_d = ts_q + 32'd1;
                            if (pkt_end) begin
                                frame_d = 8'd0;
                                if (enable) begin
                                    state_d = HDR0;
                                    batch_d = batch_eff;
                                end else begin
                                    state_d = IDLE;
                                end
                            end else begin
                                frame_d = frame_q + 8'd1;
                                state_d = HDR0;
                            end
                        end else begin
                            ch_d = ch_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rhd_aclk or negedge rhd_aresetn) begin
        if (!rhd_aresetn) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            hold_q   <= 16'd0;
            frame_q  <= 8'd0;
            batch_q  <= 8'd1;
            ts_q     <= 32'd0;
            tdata_q  <= 32'd0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            hold_q   <= hold_d;
            frame_q  <= frame_d;
            batch_q  <= batch_d;
            ts_q     <= ts_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            sync_q   <= sync_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;
    assign busy     = (state_q != IDLE);
    assign sync_err = sync_q;

endmodule

// File: tb/tb_rhd_frame_packetizer.sv
// Scoreboard bench for rhd_frame_packetizer: expected words are queued per
// frame as stimulus is issued and popped on every output handshake.
module tb_rhd_frame_packetizer;

    localparam int unsigned NCH   = 32;
    localparam logic [63:0] MAGIC = 64'hC691199927021942;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  batch_size;
    logic [15:0] s_data;
    logic        s_first;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        busy;
    logic        sync_err;

    logic [32:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    logic        rand_rdy;
    logic        stall_v;
    logic [32:0] stall_w;
    logic        acc;

    rhd_frame_packetizer #(.NUM_CH(NCH), .MAGIC(MAGIC)) dut (
        .rhd_aclk    (clk),
        .rhd_aresetn (rst_n),
        .enable      (enable),
        .batch_size  (batch_size),
        .s_data      (s_data),
        .s_first     (s_first),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .busy        (busy),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] ts, input int base, input logic last);
        exp_q.push_back({1'b0, MAGIC[31:0]});
        exp_q.push_back({1'b0, MAGIC[63:32]});
        exp_q.push_back({1'b0, ts});
        for (int k = 0; k < NCH / 2; k++) begin
            exp_q.push_back({(last && (k == NCH / 2 - 1)),
                             16'(base + 2 * k + 1), 16'(base + 2 * k)});
        end
    endtask

    // Output monitor, sampled on the falling edge
    task automatic mon();
        logic [32:0] e;
        if (!rst_n) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v && m_tvalid) chk("stall_hold", {m_tlast, m_tdata}, stall_w);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {m_tlast, m_tdata}, 64'hDEAD_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {m_tlast, m_tdata}, e);
                end
            end
            stall_v = m_tvalid && !m_tready;
            stall_w = {m_tlast, m_tdata};
        end
    endtask

    task automatic cycle(output logic a);
        @(negedge clk);
        mon();
        a = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic feed_frame(input int base, input int n, input int bad_ch,
                              input int drop_after, input logic expect_idle);
        logic a;
        for (int ch = 0; ch < n; ch++) begin
            s_valid = 1'b1;
            s_data  = 16'(base + ch);
            s_first = (ch == 0) || (ch == bad_ch);
            a = 1'b0;
            for (int t = 0; t < 200 && !a; t++) cycle(a);
            if (!a) begin
                chk("sample_timeout", 0, 1);
                s_valid = 1'b0;
                return;
            end
            if (ch == drop_after) enable = 1'b0;
        end
        s_valid = 1'b0;
        s_first = 1'b0;
        if (expect_idle) chk("busy_after_last", busy, 0);
    endtask

    task automatic drain();
        logic a;
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) cycle(a);
        cycle(a);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rand_rdy = 1'b0; stall_v = 1'b0; stall_w = '0;
        rst_n = 1'b0; enable = 1'b0; batch_size = 8'd0;
        s_data = 16'd0; s_first = 1'b0; s_valid = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sync_err", sync_err, 0);
        rst_n = 1'b1;
        cycle(acc);

        // Batch of two frames, tready held high, with enable-to-W0 latency
        batch_size = 8'd2;
        push_frame(32'd0, 0, 1'b0);
        push_frame(32'd1, 32, 1'b1);
        enable = 1'b1;
        cycle(acc);
        chk("lat_busy", busy, 1);
        chk("lat_tvalid_c1", m_tvalid, 0);
        cycle(acc);
        chk("lat_tvalid_c2", m_tvalid, 1);
        chk("lat_w0", m_tdata, 64'h27021942);
        feed_frame(0, NCH, -1, -1, 1'b0);
        feed_frame(32, NCH, -1, 0, 1'b1);
        drain();
        chk("t1_sync_err", sync_err, 0);

        // batch_size 0 behaves as 1: one frame per packet, timestamps 0,1,2
        batch_size = 8'd0;
        push_frame(32'd0, 16'h100, 1'b1);
        push_frame(32'd1, 16'h200, 1'b1);
        push_frame(32'd2, 16'h300, 1'b1);
        enable = 1'b1;
        feed_frame(16'h100, NCH, -1, -1, 1'b0);
        feed_frame(16'h200, NCH, -1, -1, 1'b0);
        feed_frame(16'h300, NCH, -1, 0, 1'b1);
        drain();

        // Same stream as the first packet under random backpressure
        rand_rdy = 1'b1;
        batch_size = 8'd2;
        push_frame(32'd0, 0, 1'b0);
        push_frame(32'd1, 32, 1'b1);
        enable = 1'b1;
        feed_frame(0, NCH, -1, -1, 1'b0);
        feed_frame(32, NCH, -1, 0, 1'b0);
        drain();
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        cycle(acc);
        chk("t3_busy", busy, 0);

        // Enable dropped after channel 10 of the first frame closes the packet there
        batch_size = 8'd4;
        push_frame(32'd0, 16'h400, 1'b1);
        enable = 1'b1;
        feed_frame(16'h400, NCH, -1, 10, 1'b1);
        drain();

        // Misplaced s_first on channel 5; restart timestamp back at 0
        batch_size = 8'd1;
        push_frame(32'd0, 16'h500, 1'b1);
        enable = 1'b1;
        feed_frame(16'h500, NCH, 5, 0, 1'b1);
        drain();
        chk("sync_set", sync_err, 1);
        cycle(acc);
        chk("sync_sticky", sync_err, 1);

        // Asynchronous reset while stalled in DATA
        batch_size = 8'd1;
        exp_q.push_back({1'b0, MAGIC[31:0]});
        exp_q.push_back({1'b0, MAGIC[63:32]});
        exp_q.push_back({1'b0, 32'd0});
        enable = 1'b1;
        cycle(acc);
        chk("sync_clear", sync_err, 0);
        feed_frame(16'h600, 2, -1, -1, 1'b0);
        m_tready = 1'b0;
        cycle(acc);
        chk("stall_tvalid", m_tvalid, 1);
        chk("stall_busy", busy, 1);
        chk("hdr_popped", exp_q.size(), 0);
        enable = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_tvalid", m_tvalid, 0);
        chk("arst_tlast", m_tlast, 0);
        chk("arst_tdata", m_tdata, 0);
        chk("arst_s_ready", s_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sync_err", sync_err, 0);
        cycle(acc);
        rst_n = 1'b1;
        m_tready = 1'b1;
        cycle(acc);
        push_frame(32'd0, 16'h700, 1'b1);
        enable = 1'b1;
        feed_frame(16'h700, NCH, -1, 0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
